// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 controller sequencing the full-round and final-round datapaths.
// Optional round-done timeout enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         error,
  output logic         busy,
  output logic         round_start,
  output logic         last_start,
  output logic [3:0]   rc,
  output logic [127:0] round_state,
  output logic [127:0] round_key,
  input  logic         round_done,
  input  logic [127:0] round_state_in,
  input  logic [127:0] round_key_in,
  input  logic         last_done,
  input  logic [127:0] last_fout
);
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;
  localparam logic [3:0] RC_LAST = 4'(NUM_ROUNDS - 1);
  if (NUM_ROUNDS < 2 || NUM_ROUNDS > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("aes_round_sequencer: illegal parameters");
  end
  state_t       st, st_n;
  logic [127:0] state_q, key_q, ct_q;
  logic [3:0]   rc_q;
  logic         issued, ov_q, err_q, tmo;
`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [7:0] T_LIM = 8'(TIMEOUT_CYCLES > 255 ? 255 : TIMEOUT_CYCLES);
  logic [7:0] wait_q;
  logic       waiting;
  assign waiting = (st == RUN && !round_done) || (st == LAST && !last_done);
  assign tmo     = waiting && wait_q == T_LIM - 8'd1;
  // Any cycle that is not a done-less wait restarts the count for the next round.
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_q <= '0;
    else wait_q <= (!waiting || tmo) ? 8'd0 : wait_q + 8'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = in_valid ? RUN : IDLE;
      RUN:     st_n = tmo ? DONE : (round_done && rc_q == RC_LAST) ? LAST : RUN;
      LAST:    st_n = (tmo || last_done) ? DONE : LAST;
      default: st_n = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st      <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rc_q    <= '0;
      issued  <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st <= st_n;
      case (st)
        IDLE: if (in_valid) begin
          state_q <= plaintext ^ key;
          key_q   <= key;
          rc_q    <= 4'd1;
          issued  <= 1'b0;
        end
        RUN: if (round_done) begin
          state_q <= round_state_in;
          key_q   <= round_key_in;
          rc_q    <= rc_q + 4'd1;
          issued  <= 1'b0;
        end else issued <= 1'b1;
        LAST: if (last_done) begin
          ct_q   <= last_fout;
          ov_q   <= 1'b1;
          issued <= 1'b0;
        end else issued <= 1'b1;
        default: if (out_ready) begin
          ov_q  <= 1'b0;
          err_q <= 1'b0;
          rc_q  <= '0;
        end
      endcase
      if (tmo) begin
        ct_q  <= '0;
        err_q <= 1'b1;
        ov_q  <= 1'b1;
      end
    end
  assign in_ready    = st == IDLE && !rst;
  assign busy        = st != IDLE;
  assign round_start = st == RUN && !issued;
  assign last_start  = st == LAST && !issued;
  assign out_valid   = ov_q;
  assign error       = err_q;
  assign ciphertext  = ct_q;
  assign rc          = rc_q;
  assign round_state = state_q;
  assign round_key   = key_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: AES-128 reference model and round-unit stubs around the sequencer.
module tb_aes_round_sequencer;
  localparam int NR  = 10;
  localparam int TMO = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] plaintext = '0, key = '0;
  logic in_ready, out_valid, error, busy, round_start, last_start, round_done, last_done;
  logic [3:0] rc;
  logic [127:0] ciphertext, round_state, round_key, round_state_in, round_key_in, last_fout;
  int n_chk = 0, n_err = 0;
  int lat_cfg = 0, hang_rc = 0, exp_rc = 1, n_rs = 0, n_ls = 0;
  logic spur_rd = 1'b0, spur_ld = 1'b0, exp_err = 1'b0;
  logic [127:0] exp_ct = '0;
  aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .plaintext(plaintext),
    .key(key), .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext),
    .error(error), .busy(busy), .round_start(round_start), .last_start(last_start), .rc(rc),
    .round_state(round_state), .round_key(round_key), .round_done(round_done),
    .round_state_in(round_state_in), .round_key_in(round_key_in), .last_done(last_done),
    .last_fout(last_fout));
  always #5 clk = ~clk;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gm(sq, sq);
      inv = gm(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] byt(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(r+4*c) -: 8] = sbox(byt(s, r + 4*((c+r)%4)));
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = byt(s, 4*c); a1 = byt(s, 4*c+1); a2 = byt(s, 4*c+2); a3 = byt(s, 4*c+3);
      o[127-32*c -: 32] = {xt(a0)^xt(a1)^a1^a2^a3, a0^xt(a1)^xt(a2)^a2^a3,
                           a0^a1^xt(a2)^xt(a3)^a3, xt(a0)^a0^a1^a2^xt(a3)};
    end
    return o;
  endfunction
  function automatic logic [7:0] rcon(input int r);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 1; i < r; i++) x = xt(x);
    return x;
  endfunction
  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rcn);
    logic [31:0] t, n0, n1, n2;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcn, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, rk;
    s = pt ^ k;
    rk = k;
    for (int r = 1; r < NR; r++) begin
      rk = key_next(rk, rcon(r));
      s = mix(sub_shift(s)) ^ rk;
    end
    return sub_shift(s) ^ key_next(rk, rcon(NR));
  endfunction
  // Round units: combinational results, done after lat_cfg wait cycles (0 = same cycle as start).
  assign round_key_in   = key_next(round_key, rcon(int'(rc)));
  assign round_state_in = mix(sub_shift(round_state)) ^ round_key_in;
  assign last_fout      = sub_shift(round_state) ^ key_next(round_key, rcon(int'(rc)));
  logic armed_r = 1'b0, armed_l = 1'b0;
  int w_r = 0, w_l = 0;
  assign round_done = spur_rd | ((round_start ? lat_cfg == 0 : armed_r && w_r == lat_cfg) && int'(rc) != hang_rc);
  assign last_done  = spur_ld | (last_start ? lat_cfg == 0 : armed_l && w_l == lat_cfg);
  always @(posedge clk or posedge rst)
    if (rst) begin
      armed_r <= 1'b0;
      armed_l <= 1'b0;
    end else begin
      if (round_start && !round_done) begin armed_r <= 1'b1; w_r <= 1; end
      else if (armed_r) begin if (round_done) armed_r <= 1'b0; else w_r <= w_r + 1; end
      if (last_start && !last_done) begin armed_l <= 1'b1; w_l <= 1; end
      else if (armed_l) begin if (last_done) armed_l <= 1'b0; else w_l <= w_l + 1; end
    end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (round_start) begin chk("rc_at_round_start", rc, exp_rc); exp_rc++; n_rs++; end
      if (last_start) begin chk("rc_at_last_start", rc, NR); n_ls++; end
      if (out_valid) begin chk("ciphertext", ciphertext, exp_ct); chk("error", error, exp_err); end
    end
  // Latency counts clock edges from the accept edge to the first edge that sees out_valid high.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] lit,
                           input int want_lat, input int bp, input logic spur);
    int cnt;
    chk("in_ready_idle", in_ready, 1);
    exp_ct = aes_enc(pt, k); exp_err = 1'b0; exp_rc = 1; n_rs = 0; n_ls = 0;
    plaintext = pt; key = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; plaintext = ~pt; key = ~k;
    chk("busy_after_accept", busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("latency", cnt + 1, want_lat);
    chk("ct_literal", ciphertext, lit);
    chk("round_start_count", n_rs, NR - 1);
    chk("last_start_count", n_ls, 1);
    repeat (bp) begin
      spur_rd = spur; spur_ld = spur;
      @(negedge clk);
      chk("ct_held", ciphertext, lit);
      chk("in_ready_held", in_ready, 0);
      chk("rc_held", rc, NR);
    end
    spur_rd = 1'b0; spur_ld = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_cleared", out_valid, 0);
    chk("in_ready_after_out", in_ready, 1);
    chk("rc_cleared", rc, 0);
  endtask
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  initial begin
    int cnt;
    chk("model_sbox_01", sbox(8'h01), 8'h7c);
    chk("model_sbox_53", sbox(8'h53), 8'hed);
    chk("model_c1", aes_enc(C1_PT, C1_K), C1_CT);
    chk("model_appb", aes_enc(B_PT, B_K), B_CT);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_flags", {out_valid, error, busy, round_start, last_start}, 0);
    chk("rst_rc", rc, 0);
    chk("rst_regs", round_state | round_key | ciphertext, 0);
    rst = 1'b0;
    @(negedge clk);
    run_block(C1_PT, C1_K, C1_CT, NR + 1, 0, 1'b0);
    run_block(B_PT, B_K, B_CT, NR + 1, 5, 1'b1);
    lat_cfg = 3;
    run_block(C1_PT, C1_K, C1_CT, NR * 4 + 1, 0, 1'b0);
    spur_rd = 1'b1; spur_ld = 1'b1;
    repeat (2) @(negedge clk);
    spur_rd = 1'b0; spur_ld = 1'b0;
    @(negedge clk);
    chk("spur_idle_flags", {busy, out_valid, in_ready}, 3'b001);
    chk("spur_idle_rc", rc, 0);
    exp_rc = 1;
    plaintext = C1_PT; key = C1_K; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (rc != 4'd5 && cnt < 500) begin @(negedge clk); cnt++; end
    chk("reached_round5", rc, 5);
    rst = 1'b1;
    #1;
    chk("abort_busy_rc", {busy, out_valid, rc}, 0);
    @(negedge clk);
    rst = 1'b0;
    lat_cfg = 0;
    @(negedge clk);
    run_block(C1_PT, C1_K, C1_CT, NR + 1, 0, 1'b0);
    hang_rc = 3; exp_ct = '0; exp_err = 1'b1; exp_rc = 1;
    plaintext = C1_PT; key = C1_K; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
    cnt = 0;
    while (!out_valid && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("timeout_latency", cnt + 1, 2 + TMO + 1);
    chk("timeout_error", error, 1);
    chk("timeout_ct", ciphertext, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("timeout_cleared", {out_valid, error, in_ready}, 3'b001);
`else
    repeat (200) @(negedge clk);
    chk("hang_busy", busy, 1);
    chk("hang_no_out", {out_valid, error}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller.
- Accepts a plaintext/key pair on a valid/ready handshake and performs the initial AddRoundKey.
- Sequences rounds 1..NUM_ROUNDS-1 through the shared full-round datapath (start/finished pulses, 4-bit rc), then one pass through the final-round unit (SubBytes, ShiftRows, key add).
- Holds the ciphertext on a valid/ready output handshake. Sits between the bus-side AES register wrapper and the round datapaths.

Parameters:
- NUM_ROUNDS, 10, total rounds including the final round; legal range 2..15, bounded by the rc width.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for a round-done pulse; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  high only in IDLE
- plaintext  input  128  block to encrypt
- key  input  128  cipher key
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  result; held stable while out_valid=1
- error  output  1  round timed out; qualifies out_valid
- busy  output  1  high when not in IDLE
- round_start  output  1  one-cycle start pulse to the full-round datapath
- last_start  output  1  one-cycle start pulse to the final-round unit
- rc  output  4  current round number, 1..NUM_ROUNDS
- round_state  output  128  state register driven to both round units
- round_key  output  128  previous round key driven to both round units
- round_done  input  1  full-round finished
- round_state_in  input  128  full-round result
- round_key_in  input  128  key produced by the full round
- last_done  input  1  final round finished
- last_fout  input  128  final-round result

Behaviour:
- Reset values (async on rst): FSM=IDLE; state, key and ciphertext registers=0; rc=0; out_valid, error, busy, round_start, last_start=0; issued flag=0; in_ready=0 while rst is high, 1 after release.
- FSM states: IDLE, RUN, LAST, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state<=plaintext^key, key_reg<=key, rc<=1, issued<=0, go to RUN.
- RUN:
  - round_start = !issued, so it pulses only on the first cycle of each round; issued<=1 after that cycle.
  - round_done is sampled every RUN cycle, including the cycle round_start is high, so zero-latency combinational rounds are supported.
  - On round_done: state<=round_state_in, key_reg<=round_key_in, issued<=0.
  - If rc==NUM_ROUNDS-1, go to LAST with rc<=NUM_ROUNDS; otherwise rc<=rc+1 and stay in RUN.
- LAST:
  - last_start pulses on the first cycle, same issued mechanism.
  - On last_done: ciphertext<=last_fout, go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE, out_valid<=0, error<=0, rc<=0. The next block is accepted no earlier than the following cycle.
- round_state and round_key are driven directly from the registers; rc is registered.
- Latency with done returned in the start cycle: out_valid rises NUM_ROUNDS+1 cycles after the accept edge (11 at default). Each round adds any wait cycles spent before its done pulse.
- round_done and last_done are ignored outside RUN and LAST respectively. A done in the wrong state is dropped and does not advance rc.
- in_valid is ignored outside IDLE; plaintext and key are not re-sampled.
- out_ready held high before out_valid has no effect. out_valid held without out_ready keeps ciphertext and error frozen indefinitely.
- rst mid-operation: immediate return to IDLE with all registers at reset values; no out_valid is produced for the aborted block.

Optional Feature:
- Macro AES_SEQ_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter, cleared at each round start, increments each RUN/LAST cycle without a done pulse.
  - On reaching TIMEOUT_CYCLES-1 without done: ciphertext<=0, error<=1, go to DONE; normal out handshake applies.
  - The counter and TIMEOUT_CYCLES are clipped at 255.
- Undefined: no counter; error tied to 0; the FSM waits forever for a done pulse.

Test Plan:
- FIPS-197 C.1 with real round units: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid 11 cycles after accept; rc sequence 1..10.
- Back-to-back with backpressure: FIPS-197 App.B pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c; out_ready held low 5 cycles -> ciphertext=3925841d02dc09fbdc118597196a0b32 stable throughout; in_ready=0 until the cycle after out_ready.
- Stub round unit returning done 3 cycles after each start -> exactly one round_start pulse per round, 9 round_start and 1 last_start total; out_valid at accept+41 cycles.
- Spurious round_done/last_done pulses in IDLE and DONE -> no state change, rc unchanged, no extra out_valid.
- rst asserted during round 5 -> same-cycle (async) return to IDLE, busy=0, rc=0; a fresh C.1 request then completes correctly.
- With AES_SEQ_TIMEOUT_EN and a stub that never returns done in round 3 -> error=1, ciphertext=0, out_valid after TIMEOUT_CYCLES wait cycles. Without the macro -> busy stays 1 and out_valid stays 0.
